// File: rtl/nibble_add_scheduler.sv
// Two-requester arbiter that runs a DW-bit addition as NIBBLES passes through
// one shared external 4-bit adder, chaining the carry through a register.
module nibble_add_scheduler #(
   parameter  int NIBBLES = 4,
   localparam int DW      = 4 * NIBBLES
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0,
   input  logic [DW-1:0] a0,
   input  logic [DW-1:0] b0,
   input  logic          cin0,
   output logic          ack0,
   input  logic          req1,
   input  logic [DW-1:0] a1,
   input  logic [DW-1:0] b1,
   input  logic          cin1,
   output logic          ack1,
   output logic [3:0]    add_x,
   output logic [3:0]    add_y,
   output logic          add_cin,
   input  logic [3:0]    add_s,
   input  logic          add_cout,
   output logic          busy,
   output logic          done,
   output logic          grant_id,
   output logic [DW-1:0] result,
   output logic          result_cout
);

   localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic [DW-1:0]   a_q;
   logic [DW-1:0]   b_q;
   logic [DW-1:0]   acc_q;
   logic [DW-1:0]   acc_d;
   logic            carry_q;
   logic            last_q;
   logic            win_d;
   logic            last_nib;
   logic [CW+1:0]   base;
   logic            ack0_q;
   logic            ack1_q;
   logic            busy_q;
   logic            done_q;
   logic            gid_q;
   logic [DW-1:0]   result_q;
   logic            rcout_q;

   assign base     = {cnt_q, 2'b00};
   assign last_nib = (cnt_q == CW'(NIBBLES - 1));

   // Tie goes to whoever was not granted last; reset leaves last_q=1 so req0 wins first.
   always_comb begin
      win_d = req1;
      if (req0 && req1) begin
         win_d = ~last_q;
      end
   end

   // Partial sums land in acc_q so result only changes once the whole sum is known.
   always_comb begin
      acc_d = acc_q;
      acc_d[base +: 4] = add_s;
   end

   always_comb begin
      add_x   = '0;
      add_y   = '0;
      add_cin = 1'b0;
      if (state_q == ST_RUN) begin
         add_x   = a_q[base +: 4];
         add_y   = b_q[base +: 4];
         add_cin = carry_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         carry_q  <= 1'b0;
         last_q   <= 1'b1;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         gid_q    <= 1'b0;
         result_q <= '0;
         rcout_q  <= 1'b0;
      end else begin
         ack0_q <= 1'b0;
         ack1_q <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req0 || req1) begin
                  a_q     <= win_d ? a1 : a0;
                  b_q     <= win_d ? b1 : b0;
                  carry_q <= win_d ? cin1 : cin0;
                  gid_q   <= win_d;
                  last_q  <= win_d;
                  cnt_q   <= '0;
                  ack0_q  <= ~win_d;
                  ack1_q  <= win_d;
                  busy_q  <= 1'b1;
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               acc_q   <= acc_d;
               carry_q <= add_cout;
               cnt_q   <= cnt_q + 1'b1;
               if (last_nib) begin
                  result_q <= acc_d;
                  rcout_q  <= add_cout;
                  done_q   <= 1'b1;
                  state_q  <= ST_DONE;
               end
            end
            ST_DONE: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign ack0        = ack0_q;
   assign ack1        = ack1_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign grant_id    = gid_q;
   assign result      = result_q;
   assign result_cout = rcout_q;

endmodule

// File: tb/tb_nibble_add_scheduler.sv
// Bench for nibble_add_scheduler: a transaction-level timeline model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_nibble_add_scheduler;

   localparam int N  = 4;
   localparam int DW = 4 * N;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req0, req1, cin0, cin1;
   logic [DW-1:0] a0, b0, a1, b1;
   logic          ack0, ack1;
   logic [3:0]    add_x, add_y, add_s;
   logic          add_cin, add_cout;
   logic          busy, done, grant_id, result_cout;
   logic [DW-1:0] result;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   nibble_add_scheduler #(.NIBBLES(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .a0(a0), .b0(b0), .cin0(cin0), .ack0(ack0),
      .req1(req1), .a1(a1), .b1(b1), .cin1(cin1), .ack1(ack1),
      .add_x(add_x), .add_y(add_y), .add_cin(add_cin),
      .add_s(add_s), .add_cout(add_cout),
      .busy(busy), .done(done), .grant_id(grant_id),
      .result(result), .result_cout(result_cout)
   );

   // The shared 4-bit adder lives outside the block.
   assign {add_cout, add_s} = {1'b0, add_x} + {1'b0, add_y} + {4'b0, add_cin};

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic timeout(input string nm);
      n_checks++;
      $display("FAIL %s: timed out waiting for DUT (t=%0t)", nm, $time);
   endtask

   // Model: m_k counts cycles since the grant edge (0 = idle, 1..N run, N+1 done).
   int            m_k     = 0;
   bit            m_valid = 0;
   logic [DW-1:0] m_a, m_b, m_result;
   logic          m_cin, m_gid, m_last, m_rcout;
   logic          w;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_k = 0; m_last = 1'b1; m_gid = 1'b0;
         m_result = '0; m_rcout = 1'b0; m_a = '0; m_b = '0; m_cin = 1'b0;
         m_valid = 1;
      end else if (m_valid) begin
         if (m_k == 0) begin
            if (req0 || req1) begin
               w = (req0 && req1) ? !m_last : req1;
               m_a = w ? a1 : a0; m_b = w ? b1 : b0; m_cin = w ? cin1 : cin0;
               m_gid = w; m_last = w; m_k = 1;
            end
         end else begin
            if (m_k == N)
               {m_rcout, m_result} = {1'b0, m_a} + {1'b0, m_b} + {{DW{1'b0}}, m_cin};
            m_k = (m_k == N + 1) ? 0 : m_k + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         logic [63:0] ex, ey, ec, lo;
         int j;
         ex = 0; ey = 0; ec = 0;
         if (m_k >= 1 && m_k <= N) begin
            j  = m_k - 1;
            lo = (64'd1 << (4 * j)) - 64'd1;
            ex = ({48'b0, m_a} >> (4 * j)) & 64'hF;
            ey = ({48'b0, m_b} >> (4 * j)) & 64'hF;
            ec = ((({48'b0, m_a} & lo) + ({48'b0, m_b} & lo) + {63'b0, m_cin}) >> (4 * j)) & 64'h1;
         end
         chk("m_ack0", ack0, (m_k == 1 && !m_gid));
         chk("m_ack1", ack1, (m_k == 1 && m_gid));
         chk("m_add_x", add_x, ex);
         chk("m_add_y", add_y, ey);
         chk("m_add_cin", add_cin, ec);
         chk("m_busy", busy, (m_k >= 1));
         chk("m_done", done, (m_k == N + 1));
         chk("m_grant_id", grant_id, m_gid);
         chk("m_result", result, m_result);
         chk("m_result_cout", result_cout, m_rcout);
      end
   end

   task automatic wait_idle();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy === 1'b0) return;
      end
      timeout("wait_idle");
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Single request with literal expectations on ack, per-nibble adder drive and result.
   task automatic single(input string nm, input bit who, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic c, input logic [DW-1:0] exp_x, input logic [N-1:0] exp_cin,
                         input logic [DW-1:0] exp_res, input logic exp_co);
      wait_idle();
      if (who) begin req1 = 1'b1; a1 = a; b1 = b; cin1 = c; end
      else     begin req0 = 1'b1; a0 = a; b0 = b; cin0 = c; end
      @(negedge clk);
      chk({nm, "_ack"}, who ? ack1 : ack0, 1);
      req0 = 1'b0; req1 = 1'b0;
      a0 = 16'($urandom); a1 = 16'($urandom);
      for (int i = 0; i < N; i++) begin
         if (i > 0) @(negedge clk);
         chk({nm, "_add_x"}, add_x, exp_x[4*i +: 4]);
         chk({nm, "_add_cin"}, add_cin, exp_cin[i]);
      end
      @(negedge clk);
      chk({nm, "_done"}, done, 1);
      chk({nm, "_result"}, result, exp_res);
      chk({nm, "_cout"}, result_cout, exp_co);
      chk({nm, "_gid"}, grant_id, who);
   endtask

   int done_cyc[$];
   int done_gid[$];

   initial begin
      rst_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0; cin0 = 1'b0; cin1 = 1'b0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_result", result, 0);
      rst_n = 1'b1;

      single("t1", 1'b0, 16'h1234, 16'h0FCD, 1'b0, 16'h1234, 4'b1110, 16'h2201, 1'b0);
      single("t2", 1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 4'b1110, 16'h0000, 1'b1);
      single("t3", 1'b0, 16'h7FFF, 16'h8000, 1'b1, 16'h7FFF, 4'b1111, 16'h0000, 1'b1);

      // Both requesters hammer continuously from reset.
      wait_idle();
      do_reset();
      req0 = 1'b1; a0 = 16'($urandom); b0 = 16'($urandom); cin0 = 1'($urandom);
      req1 = 1'b1; a1 = 16'($urandom); b1 = 16'($urandom); cin1 = 1'($urandom);
      for (int c = 1; c <= 26; c++) begin
         @(negedge clk);
         if (ack0) begin a0 = 16'($urandom); b0 = 16'($urandom); cin0 = 1'($urandom); end
         if (ack1) begin a1 = 16'($urandom); b1 = 16'($urandom); cin1 = 1'($urandom); end
         if (done) begin done_cyc.push_back(c); done_gid.push_back(int'(grant_id)); end
      end
      req0 = 1'b0; req1 = 1'b0;
      chk("t4_ndone", done_cyc.size(), 4);
      if (done_cyc.size() >= 4) begin
         for (int i = 0; i < 4; i++) begin
            chk("t4_order", done_gid[i], i % 2);
            chk("t4_when", done_cyc[i], 5 + 6 * i);
         end
      end

      // Reset in the second RUN cycle aborts; pointer returns to favouring req0.
      wait_idle();
      req0 = 1'b1; a0 = 16'h4321; b0 = 16'h1111; cin0 = 1'b0;
      @(negedge clk);
      req0 = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("t5_ack0", ack0, 0);
      chk("t5_ack1", ack1, 0);
      chk("t5_add_x", add_x, 0);
      chk("t5_add_y", add_y, 0);
      chk("t5_add_cin", add_cin, 0);
      chk("t5_busy", busy, 0);
      chk("t5_done", done, 0);
      chk("t5_gid", grant_id, 0);
      chk("t5_result", result, 0);
      chk("t5_cout", result_cout, 0);
      rst_n = 1'b1;
      req0 = 1'b1; a0 = 16'h1111; b0 = 16'h2222; cin0 = 1'b0;
      req1 = 1'b1; a1 = 16'h5555; b1 = 16'h5555; cin1 = 1'b1;
      @(negedge clk);
      chk("t5_regrant_ack0", ack0, 1);
      chk("t5_regrant_ack1", ack1, 0);
      req0 = 1'b0; req1 = 1'b0;

      // Quiet period: outputs idle, last result held.
      wait_idle();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t6_busy", busy, 0);
         chk("t6_done", done, 0);
         chk("t6_ack", {ack0, ack1}, 0);
         chk("t6_adder", {add_x, add_y, add_cin}, 0);
         chk("t6_result", result, 16'h3333);
         chk("t6_cout", result_cout, 0);
      end

      // Randomized traffic with occasional resets, judged by the model.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rst_n = ($urandom_range(0, 249) != 0);
         if (req0 && ack0) begin
            req0 = ($urandom_range(0, 3) == 0);
            a0 = 16'($urandom); b0 = 16'($urandom); cin0 = 1'($urandom);
         end else if (!req0 && $urandom_range(0, 2) == 0) begin
            req0 = 1'b1;
            a0 = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
            b0 = 16'($urandom); cin0 = 1'($urandom);
         end
         if (req1 && ack1) begin
            req1 = ($urandom_range(0, 3) == 0);
            a1 = 16'($urandom); b1 = 16'($urandom); cin1 = 1'($urandom);
         end else if (!req1 && $urandom_range(0, 2) == 0) begin
            req1 = 1'b1;
            a1 = 16'($urandom);
            b1 = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
            cin1 = 1'($urandom);
         end
      end
      rst_n = 1'b1; req0 = 1'b0; req1 = 1'b0;
      wait_idle();
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
